// File: rtl/gpu_instr_dispatch.sv
// Instruction dispatcher for gpuCore: prefetches a program from a synchronous ROM
// through a small FIFO and issues it one word at a time on the core handshake.
module gpu_instr_dispatch #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic [ADDR_W-1:0] progLength,
  output logic              imemRe,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [31:0]       imemData,
  output logic [31:0]       instruction,
  output logic              executeInstruction,
  input  logic              readyForNextInstruction,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PC_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dispatchState_t;

  dispatchState_t    state, stateNext;
  logic [ADDR_W-1:0] progLen;
  logic [PC_W-1:0]   fetchPc, fetchAddr, issuedCnt;
  logic              rdValid;
  logic              lockout;

  logic [31:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  fifoCount;

  logic              startGo, fetchGo, issueGo, doneGo;
  logic              push, pop, bypass, fifoAvail;
  logic [CNT_W:0]    pending;
  logic [31:0]       headData;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state plus fetch/issue/done decisions for the coming edge
  always_comb begin
    stateNext = state;
    startGo   = 1'b0;
    fetchGo   = 1'b0;
    issueGo   = 1'b0;
    doneGo    = 1'b0;
    fetchAddr = fetchPc;
    pending   = (CNT_W+1)'(fifoCount) + (CNT_W+1)'(imemRe) + (CNT_W+1)'(rdValid);
    fifoAvail = (fifoCount != '0) || rdValid;
    headData  = (fifoCount == '0) ? imemData : fifoMem[rdPtr];
    case (state)
      IDLE: begin
        if (start) begin
          startGo = 1'b1;
          if (progLength == '0) begin
            stateNext = DRAIN;
          end else begin
            stateNext = RUN;
            fetchGo   = 1'b1;
            fetchAddr = '0;
          end
        end
      end
      RUN: begin
        if ((fetchPc < PC_W'(progLen)) && (pending < (CNT_W+1)'(FIFO_DEPTH)))
          fetchGo = 1'b1;
        if (fifoAvail && readyForNextInstruction && !lockout)
          issueGo = 1'b1;
        if (issuedCnt == PC_W'(progLen))
          stateNext = DRAIN;
      end
      DRAIN: begin
        if (readyForNextInstruction && !lockout) begin
          stateNext = IDLE;
          doneGo    = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ROM data lands one cycle after the strobe; an empty FIFO forwards it directly
  assign push   = rdValid;
  assign pop    = issueGo;
  assign bypass = push && pop && (fifoCount == '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      imemRe             <= 1'b0;
      imemAddr           <= '0;
      rdValid            <= 1'b0;
      fetchPc            <= '0;
      issuedCnt          <= '0;
      progLen            <= '0;
      instruction        <= '0;
      executeInstruction <= 1'b0;
      pc                 <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      lockout            <= 1'b0;
    end else begin
      imemRe  <= fetchGo;
      rdValid <= imemRe;
      if (fetchGo) begin
        imemAddr <= fetchAddr[ADDR_W-1:0];
        fetchPc  <= fetchAddr + PC_W'(1);
      end else if (startGo) begin
        fetchPc <= '0;
      end
      if (startGo) begin
        progLen   <= progLength;
        issuedCnt <= '0;
      end
      if (issueGo) begin
        instruction <= headData;
        pc          <= issuedCnt[ADDR_W-1:0];
        issuedCnt   <= issuedCnt + PC_W'(1);
      end
      executeInstruction <= issueGo;
      done               <= doneGo;
      busy               <= (stateNext != IDLE);
      // Ready must be seen low once before the next issue is allowed
      if (issueGo)                       lockout <= 1'b1;
      else if (!readyForNextInstruction) lockout <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push && !bypass) wrPtr <= wrPtr + PTR_W'(1);
      if (pop && !bypass)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bypass) fifoMem[wrPtr] <= imemData;
  end

endmodule

// File: tb/tb_gpu_instr_dispatch.sv
// Bench for gpu_instr_dispatch: ROM and gpuCore ready behaviour are modelled here,
// and every issue is checked against program order and the handshake rules.
module tb_gpu_instr_dispatch;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [7:0]  progLength;
  logic        imemRe;
  logic [7:0]  imemAddr;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic        executeInstruction;
  logic        readyForNextInstruction;
  logic        busy;
  logic        done;
  logic [7:0]  pc;

  always #5 clk = ~clk;

  gpu_instr_dispatch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .start                   (start),
    .progLength              (progLength),
    .imemRe                  (imemRe),
    .imemAddr                (imemAddr),
    .imemData                (imemData),
    .instruction             (instruction),
    .executeInstruction      (executeInstruction),
    .readyForNextInstruction (readyForNextInstruction),
    .busy                    (busy),
    .done                    (done),
    .pc                      (pc)
  );

  typedef struct {
    int len;
    int hiHold;
    int loLen;
    int expLat;
  } vec_t;

  logic [31:0] rom [256];
  int checks = 0;
  int errors = 0;
  int curLen, readCnt, issueCnt, doneCnt, busyCnt, steps, firstExec;
  int hiHold, loLen, hiLeft, loLeft;
  bit forceLow, modelLock, pendRd;
  logic [7:0]  pendAddr;
  logic [31:0] lastInstr;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // One clock: ROM model, output checks against program order, core ready model
  task automatic step();
    @(posedge clk);
    #1;
    steps++;
    imemData = pendRd ? rom[pendAddr] : $urandom;
    pendRd   = imemRe;
    pendAddr = imemAddr;
    if (busy) busyCnt++;
    if (imemRe) begin
      chk("readAddr", longint'(imemAddr), longint'(readCnt));
      chk("readInRange", longint'(readCnt < curLen), 1);
      readCnt++;
      chk("fifoBound", longint'((readCnt - issueCnt) <= FIFO_DEPTH), 1);
    end
    if (executeInstruction) begin
      chk("issueNeedsReadyLowFirst", longint'(modelLock), 0);
      chk("issueReadyHigh", longint'(readyForNextInstruction), 1);
      chk("issueInRange", longint'(issueCnt < curLen), 1);
      chk("issueWord", longint'(instruction), longint'(rom[issueCnt & 255]));
      chk("issuePc", longint'(pc), longint'(issueCnt & 255));
      if (firstExec < 0) firstExec = steps;
      issueCnt++;
      modelLock = 1'b1;
      hiLeft    = hiHold;
      loLeft    = loLen;
    end else begin
      chk("instrHold", longint'(instruction), longint'(lastInstr));
      if (!readyForNextInstruction) modelLock = 1'b0;
    end
    lastInstr = instruction;
    if (done) begin
      chk("doneAfterAll", longint'(issueCnt), longint'(curLen));
      chk("doneBusyLow", longint'(busy), 0);
      doneCnt++;
    end
    if (forceLow) readyForNextInstruction = 1'b0;
    else if (hiLeft > 0) begin readyForNextInstruction = 1'b1; hiLeft--; end
    else if (loLeft > 0) begin readyForNextInstruction = 1'b0; loLeft--; end
    else readyForNextInstruction = 1'b1;
  endtask

  task automatic startProgram(input int len);
    curLen = len; readCnt = 0; issueCnt = 0; doneCnt = 0;
    busyCnt = 0; steps = 0; firstExec = -1;
    progLength = 8'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    progLength = 8'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneCnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk("doneSeen", longint'(doneCnt), 1);
    repeat (3) step();
    chk("singleDone", longint'(doneCnt), 1);
    chk("allIssued", longint'(issueCnt), longint'(curLen));
    chk("allRead", longint'(readCnt), longint'(curLen));
    chk("idleAfter", longint'(busy), 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "Busy"}, longint'(busy), 0);
    chk({tag, "Exec"}, longint'(executeInstruction), 0);
    chk({tag, "Done"}, longint'(done), 0);
    chk({tag, "Pc"}, longint'(pc), 0);
    chk({tag, "Instr"}, longint'(instruction), 0);
    chk({tag, "ImemRe"}, longint'(imemRe), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    vec_t v;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0580_0001;
    rom[1] = 32'h1680_0000;
    rom[2] = 32'hBBD8_0000;

    vecs[0] = '{3, 1, 1, 3};
    vecs[1] = '{1, 1, 1, 3};
    vecs[2] = '{8, 10, 1, 3};
    vecs[3] = '{5, 2, 3, 3};
    vecs[4] = '{0, 1, 1, -1};
    vecs[5] = '{255, 1, 1, 3};
    vecs[6] = '{17, 3, 2, 3};
    vecs[7] = '{2, 1, 4, 3};

    resetN = 1'b0; start = 1'b0; progLength = '0; imemData = '0;
    readyForNextInstruction = 1'b1;
    forceLow = 1'b0; modelLock = 1'b0; pendRd = 1'b0; pendAddr = '0;
    hiHold = 1; loLen = 1; hiLeft = 0; loLeft = 0; lastInstr = '0;
    curLen = 0; readCnt = 0; issueCnt = 0; doneCnt = 0; busyCnt = 0; steps = 0; firstExec = -1;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) step();

    // Table of programs under different core ready patterns
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      hiHold = v.hiHold;
      loLen  = v.loLen;
      startProgram(v.len);
      waitDone(v.len * (v.hiHold + v.loLen + 4) + 50);
      chk("firstIssueLatency", longint'(firstExec), longint'(v.expLat));
      if (v.len > 0) chk("holdLast", longint'(instruction), longint'(rom[v.len - 1]));
    end

    // Randomised programs and ready timing
    for (int i = 0; i < 8; i++) begin
      int len;
      len    = int'($urandom_range(0, 40));
      hiHold = int'($urandom_range(1, 5));
      loLen  = int'($urandom_range(1, 4));
      startProgram(len);
      waitDone(len * (hiHold + loLen + 4) + 50);
      chk("randLatency", longint'(firstExec), (len == 0) ? -1 : 3);
    end

    // Ready held low: prefetch fills the FIFO and stalls, then everything drains in order
    hiHold = 1; loLen = 1;
    forceLow = 1'b1;
    readyForNextInstruction = 1'b0;
    startProgram(8);
    repeat (20) step();
    chk("stallReads", longint'(readCnt), longint'(FIFO_DEPTH));
    chk("stallNoIssue", longint'(issueCnt), 0);
    chk("stallImemReLow", longint'(imemRe), 0);
    forceLow = 1'b0;
    waitDone(200);

    // Zero-length program
    startProgram(0);
    waitDone(20);
    chk("zeroLenBusyCycles", longint'(busyCnt), 1);

    // Start while busy is ignored
    hiHold = 2; loLen = 1;
    startProgram(6);
    repeat (4) step();
    progLength = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    waitDone(200);
    chk("restartIgnoredLast", longint'(instruction), longint'(rom[5]));

    // Reset in the middle of a program
    hiHold = 1; loLen = 1;
    startProgram(20);
    repeat (10) step();
    chk("preResetBusy", longint'(busy), 1);
    resetN = 1'b0;
    #1;
    checkResetOutputs("midReset");
    curLen = 0; readCnt = 0; issueCnt = 0; doneCnt = 0;
    modelLock = 1'b0; pendRd = 1'b0; lastInstr = '0; hiLeft = 0; loLeft = 0;
    repeat (3) step();
    chk("noDoneInReset", longint'(doneCnt), 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) step();
    chk("noDoneAfterAbort", longint'(doneCnt), 0);
    startProgram(4);
    waitDone(100);
    chk("afterResetLatency", longint'(firstExec), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
